// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-back arbiter: write source
// encodings, register-file geometry and a one-hot decode helper.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_LL   = 2'd2
  } wb_src_e;

  function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return REG_NUM'(1) << r;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO buffering long-latency results ({rd, data}).
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_arb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p0, rd_ptr_p0;
  logic [PTR_W:0]   count_p0;
  logic             do_push, do_pop;

  assign full    = (count_p0 == (PTR_W+1)'(DEPTH));
  assign empty   = (count_p0 == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_p0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (do_push) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (do_pop)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Storage carries data only; occupancy/pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_p0] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB beats buffered long-latency
// results; a pending-write scoreboard stalls decode. Optional LL_BYPASS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int LL_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_wr,
  input  logic [DATA_W-1:0]     pipe_wd,
  input  logic                  ll_issue,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [DATA_W-1:0]     ll_data,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_valid,
  output logic                  hazard_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [1:0]            dbg_wb_src
);

  localparam int ENT_W = DATA_W + REG_ADDR_W;

  logic                  alive_p0;
  logic [REG_NUM-1:0]    sb_p0;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENT_W-1:0]      fifo_head;
  logic                  ll_accept, pipe_sel, bypass, ll_commit;
  logic [REG_ADDR_W-1:0] commit_rd;
  logic [REG_NUM-1:0]    sb_next;
  wb_src_e               src;

  assign ll_ready  = alive_p0 & ~fifo_full;
  assign ll_accept = ll_valid & ll_ready;
  assign pipe_sel  = rst_n & pipe_we & (pipe_wr != '0);

`ifdef LL_BYPASS_EN
  assign bypass = ll_accept & (ll_rd != '0) & fifo_empty & ~pipe_sel;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_pop  = ~pipe_sel & ~fifo_empty;
  assign fifo_push = ll_accept & (ll_rd != '0) & ~bypass;

  rf_arb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LL_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({ll_rd, ll_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    src   = WB_SRC_NONE;
    rf_we = 1'b0;
    rf_wr = '0;
    rf_wd = '0;
    if (pipe_sel) begin
      src   = WB_SRC_PIPE;
      rf_we = 1'b1;
      rf_wr = pipe_wr;
      rf_wd = pipe_wd;
    end else if (!fifo_empty) begin
      src   = WB_SRC_LL;
      rf_we = 1'b1;
      rf_wr = fifo_head[ENT_W-1 -: REG_ADDR_W];
      rf_wd = fifo_head[DATA_W-1:0];
    end else if (bypass) begin
      src   = WB_SRC_LL;
      rf_we = 1'b1;
      rf_wr = ll_rd;
      rf_wd = ll_data;
    end
  end

  assign dbg_wb_src = src;

  // Scoreboard: clear on LL commit, then set on issue so set wins; x0 never pending.
  assign ll_commit = fifo_pop | bypass;
  assign commit_rd = fifo_pop ? fifo_head[ENT_W-1 -: REG_ADDR_W] : ll_rd;

  always_comb begin
    sb_next = sb_p0;
    if (ll_commit) sb_next = sb_next & ~reg_onehot(commit_rd);
    if (ll_issue)  sb_next = sb_next | reg_onehot(ll_issue_rd);
    sb_next[0] = 1'b0;
  end

  assign hazard_stall = sb_p0[id_rs1] | sb_p0[id_rs2] | (id_rd_valid & sb_p0[id_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_p0 <= 1'b0;
      sb_p0    <= '0;
    end else begin
      alive_p0 <= 1'b1;
      sb_p0    <= sb_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed steps plus randomized traffic against a
// queue-based reference model. Follows LL_BYPASS_EN when defined.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
`ifdef LL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_wr;
  logic [31:0] pipe_wd;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_valid;
  logic        hazard_stall;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [1:0]  dbg_wb_src;

  rf_wb_arbiter #(.DATA_W(32), .LL_FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_we      (pipe_we),
    .pipe_wr      (pipe_wr),
    .pipe_wd      (pipe_wd),
    .ll_issue     (ll_issue),
    .ll_issue_rd  (ll_issue_rd),
    .ll_valid     (ll_valid),
    .ll_rd        (ll_rd),
    .ll_data      (ll_data),
    .ll_ready     (ll_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_rd_valid  (id_rd_valid),
    .hazard_stall (hazard_stall),
    .rf_we        (rf_we),
    .rf_wr        (rf_wr),
    .rf_wd        (rf_wd),
    .dbg_wb_src   (dbg_wb_src)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: pending results as a queue, pending regs as a bit array.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   pend[32];
  bit   alive;
  bit   m_pop, m_byp, m_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    alive = 1'b0;
  endtask

  task automatic settle_check();
    logic        e_we, e_stall;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic [1:0]  e_src;
    #1;
    if (!rst_n) model_reset();
    m_ready = alive && (q.size() < DEPTH);
    m_pop = 1'b0;
    m_byp = 1'b0;
    e_we = 1'b0; e_wr = '0; e_wd = '0; e_src = 2'd0;
    if (rst_n && pipe_we && pipe_wr != 0) begin
      e_we = 1'b1; e_wr = pipe_wr; e_wd = pipe_wd; e_src = 2'd1;
    end else if (q.size() > 0) begin
      e_we = 1'b1; e_wr = q[0].rd; e_wd = q[0].d; e_src = 2'd2; m_pop = 1'b1;
    end else if (BYPASS && ll_valid && m_ready && ll_rd != 0) begin
      e_we = 1'b1; e_wr = ll_rd; e_wd = ll_data; e_src = 2'd2; m_byp = 1'b1;
    end
    e_stall = pend[id_rs1] | pend[id_rs2] | (id_rd_valid & pend[id_rd]);
    chk("rf_we", rf_we, e_we);
    chk("rf_wr", rf_wr, e_wr);
    chk("rf_wd", rf_wd, e_wd);
    chk("dbg_wb_src", dbg_wb_src, e_src);
    chk("ll_ready", ll_ready, m_ready);
    chk("hazard_stall", hazard_stall, e_stall);
  endtask

  task automatic advance();
    logic [4:0] crd;
    if (rst_n) begin
      if (m_pop) begin
        crd = q[0].rd;
        pend[crd] = 1'b0;
        void'(q.pop_front());
      end
      if (m_byp) pend[ll_rd] = 1'b0;
      if (ll_valid && m_ready && ll_rd != 0 && !m_byp) q.push_back(ent_t'{rd: ll_rd, d: ll_data});
      if (ll_issue && ll_issue_rd != 0) pend[ll_issue_rd] = 1'b1;
      alive = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_wr = 0; pipe_wd = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_valid = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Reset with a producer offering a result
    ll_valid = 1; ll_rd = 6; ll_data = 32'h1111_2222;
    settle_check();
    chk("rst_ll_ready", ll_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    advance();
    step();
    rst_n = 1'b1; ll_valid = 0;
    step();
    settle_check();
    chk("post_rst_ready", ll_ready, 1'b1);
    advance();

    // Pipe-only writes
    pipe_we = 1; pipe_wr = 5; pipe_wd = 32'hDEAD_BEEF;
    settle_check();
    chk("pipe_we", rf_we, 1'b1);
    chk("pipe_wr", rf_wr, 5'd5);
    chk("pipe_wd", rf_wd, 32'hDEAD_BEEF);
    chk("pipe_src", dbg_wb_src, 2'd1);
    advance();
    pipe_wr = 0;
    settle_check();
    chk("pipe_x0_we", rf_we, 1'b0);
    advance();

    // Collision: x3 from pipe three cycles, ll x7 accepted in the first
    pipe_wr = 3; pipe_wd = 32'h3333_0000;
    ll_valid = 1; ll_rd = 7; ll_data = 32'h0000_1234;
    settle_check();
    chk("coll_wr0", rf_wr, 5'd3);
    advance();
    ll_valid = 0;
    for (int i = 0; i < 2; i++) begin
      settle_check();
      chk("coll_wr", rf_wr, 5'd3);
      advance();
    end
    pipe_we = 0;
    settle_check();
    chk("coll_ll_wr", rf_wr, 5'd7);
    chk("coll_ll_wd", rf_wd, 32'h0000_1234);
    chk("coll_ll_src", dbg_wb_src, 2'd2);
    advance();

    // FIFO fill under continuous pipe writes, third result held by producer
    pipe_we = 1; pipe_wr = 1; pipe_wd = 32'h0101_0101;
    ll_valid = 1; ll_rd = 10; ll_data = 32'hA;
    step();
    ll_rd = 11; ll_data = 32'hB;
    step();
    ll_rd = 12; ll_data = 32'hC;
    settle_check();
    chk("full_ready", ll_ready, 1'b0);
    advance();
    pipe_we = 0;
    settle_check();
    chk("drain0_wr", rf_wr, 5'd10);
    advance();
    settle_check();
    chk("drain1_wr", rf_wr, 5'd11);
    advance();
    ll_valid = 0;
    settle_check();
    chk("drain2_wr", rf_wr, 5'd12);
    chk("drain2_wd", rf_wd, 32'hC);
    advance();
    settle_check();
    chk("drained_ready", ll_ready, 1'b1);
    advance();

    // Scoreboard on x9
    ll_issue = 1; ll_issue_rd = 9;
    step();
    ll_issue = 0; id_rs2 = 9;
    settle_check();
    chk("sb_stall_set", hazard_stall, 1'b1);
    advance();
    id_rs2 = 0; id_rs1 = 0; id_rd = 0; id_rd_valid = 1;
    settle_check();
    chk("sb_x0_nostall", hazard_stall, 1'b0);
    advance();
    id_rs2 = 9; id_rd_valid = 0;
    ll_valid = 1; ll_rd = 9; ll_data = 32'h9999;
    settle_check();
    chk("sb_accept_stall", hazard_stall, 1'b1);
    advance();
    ll_valid = 0;
    settle_check();
    chk("sb_commit_stall", hazard_stall, BYPASS ? 1'b0 : 1'b1);
    advance();
    settle_check();
    chk("sb_cleared", hazard_stall, 1'b0);
    advance();
    id_rs2 = 0;

`ifdef LL_BYPASS_EN
    ll_issue = 1; ll_issue_rd = 4;
    step();
    ll_issue = 0; id_rs1 = 4;
    ll_valid = 1; ll_rd = 4; ll_data = 32'hA5A5_A5A5;
    settle_check();
    chk("byp_we", rf_we, 1'b1);
    chk("byp_wr", rf_wr, 5'd4);
    chk("byp_wd", rf_wd, 32'hA5A5_A5A5);
    advance();
    ll_valid = 0;
    settle_check();
    chk("byp_sb_clear", hazard_stall, 1'b0);
    advance();
    id_rs1 = 0;
`endif

    // Randomized traffic with occasional mid-operation reset
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 149) != 0);
      pipe_we     = ($urandom_range(0, 2) == 0);
      pipe_wr     = 5'($urandom_range(0, 31));
      pipe_wd     = $urandom;
      ll_valid    = ($urandom_range(0, 1) == 1);
      ll_rd       = 5'($urandom_range(0, 31));
      ll_data     = $urandom;
      ll_issue_rd = 5'($urandom_range(0, 31));
      ll_issue    = ($urandom_range(0, 2) == 0) && !pend[ll_issue_rd];
      id_rs1      = 5'($urandom_range(0, 31));
      id_rs2      = 5'($urandom_range(0, 31));
      id_rd       = 5'($urandom_range(0, 31));
      id_rd_valid = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
